// File: rtl/univ_shift_reg_if.sv
// Bus bundle for univ_shift_reg: control and data in, word and status out.
interface univ_shift_reg_if #(
   parameter int unsigned WIDTH = 8
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic             en;
   logic [2:0]       mode;
   logic [WIDTH-1:0] din;
   logic             sin_r;
   logic             sin_l;
   logic [WIDTH-1:0] q;
   logic             sout_msb;
   logic             sout_lsb;
   logic [CW-1:0]    cnt;
   logic             done;
   logic             done_pulse;

   // Driver side: issues operations, observes the word and counters.
   modport master (
      output en, mode, din, sin_r, sin_l,
      input  q, sout_msb, sout_lsb, cnt, done, done_pulse
   );

   // Register side: executes operations, publishes state.
   modport slave (
      input  en, mode, din, sin_r, sin_l,
      output q, sout_msb, sout_lsb, cnt, done, done_pulse
   );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold, shifts, rotates, load, clear, arithmetic
// shift right, plus a saturating shift counter with level and pulse completion flags.
module univ_shift_reg #(
   parameter int unsigned     WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic               clk,
   input  logic               rst,
   univ_shift_reg_if.slave    bus
);
   localparam int unsigned   CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHL  = 3'b001;
   localparam logic [2:0] MODE_SHR  = 3'b010;
   localparam logic [2:0] MODE_ROL  = 3'b011;
   localparam logic [2:0] MODE_ROR  = 3'b100;
   localparam logic [2:0] MODE_LOAD = 3'b101;
   localparam logic [2:0] MODE_CLR  = 3'b110;
   localparam logic [2:0] MODE_ASR  = 3'b111;

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_nxt;
   logic [CW-1:0]    cnt_r;
   logic [CW-1:0]    cnt_nxt;
   logic             done_r;
   logic             done_nxt;
   logic             pulse_r;
   logic             pulse_nxt;
   logic             incr;
   logic             zero_cnt;

   // Next-state decode for word, counter and completion flags.
   always_comb begin
      q_nxt     = q_r;
      cnt_nxt   = cnt_r;
      pulse_nxt = 1'b0;
      incr      = 1'b0;
      zero_cnt  = 1'b0;

      if (bus.en) begin
         case (bus.mode)
            MODE_HOLD: q_nxt = q_r;
            MODE_SHL: begin
               q_nxt = {q_r[WIDTH-2:0], bus.sin_r};
               incr  = 1'b1;
            end
            MODE_SHR: begin
               q_nxt = {bus.sin_l, q_r[WIDTH-1:1]};
               incr  = 1'b1;
            end
            MODE_ROL: begin
               q_nxt = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
               incr  = 1'b1;
            end
            MODE_ROR: begin
               q_nxt = {q_r[0], q_r[WIDTH-1:1]};
               incr  = 1'b1;
            end
            MODE_LOAD: begin
               q_nxt    = bus.din;
               zero_cnt = 1'b1;
            end
            MODE_CLR: begin
               q_nxt    = '0;
               zero_cnt = 1'b1;
            end
            MODE_ASR: begin
               q_nxt = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
               incr  = 1'b1;
            end
         endcase
      end

      // Counter saturates at WIDTH; the pulse marks only the step onto WIDTH.
      if (zero_cnt) begin
         cnt_nxt = '0;
      end else if (incr) begin
         if (cnt_r != CNT_MAX) cnt_nxt = cnt_r + CW'(1);
         pulse_nxt = (cnt_r == CNT_LAST);
      end

      done_nxt = (cnt_nxt == CNT_MAX);
   end

   // State register with synchronous reset taking priority over enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_r     <= RST_VAL;
         cnt_r   <= '0;
         done_r  <= 1'b0;
         pulse_r <= 1'b0;
      end else begin
         q_r     <= q_nxt;
         cnt_r   <= cnt_nxt;
         done_r  <= done_nxt;
         pulse_r <= pulse_nxt;
      end
   end

   assign bus.q          = q_r;
   assign bus.cnt        = cnt_r;
   assign bus.done       = done_r;
   assign bus.done_pulse = pulse_r;
   assign bus.sout_msb   = q_r[WIDTH-1];
   assign bus.sout_lsb   = q_r[0];
endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios plus random operations against
// an arithmetic reference model of the register and its counter.
module tb_univ_shift_reg;
   localparam int unsigned W   = 8;
   localparam logic [7:0]  RSV = 8'hA5;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   int   mq;
   int   mcnt;
   int   mdone;
   int   mpulse;

   univ_shift_reg_if #(.WIDTH(W)) bus ();

   univ_shift_reg #(.WIDTH(W), .RST_VAL(RSV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point for every check in the bench.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance the model, compare all outputs.
   task automatic step(input logic r, input logic e, input logic [2:0] m,
                       input logic [7:0] d, input logic sr, input logic sl);
      int nq;
      int inc;
      @(negedge clk);
      rst       = r;
      bus.en    = e;
      bus.mode  = m;
      bus.din   = d;
      bus.sin_r = sr;
      bus.sin_l = sl;
      @(posedge clk);
      nq  = mq;
      inc = 0;
      if (r) begin
         mq = int'(RSV); mcnt = 0; mdone = 0; mpulse = 0;
      end else if (!e) begin
         mpulse = 0;
      end else begin
         case (m)
            3'd0: nq = mq;
            3'd1: begin nq = (mq * 2 + int'(sr)) % 256; inc = 1; end
            3'd2: begin nq = mq / 2 + int'(sl) * 128; inc = 1; end
            3'd3: begin nq = (mq * 2) % 256 + mq / 128; inc = 1; end
            3'd4: begin nq = mq / 2 + (mq % 2) * 128; inc = 1; end
            3'd5: begin nq = int'(d); mcnt = 0; end
            3'd6: begin nq = 0; mcnt = 0; end
            default: begin nq = mq / 2 + ((mq >= 128) ? 128 : 0); inc = 1; end
         endcase
         mpulse = (inc == 1 && mcnt == int'(W) - 1) ? 1 : 0;
         if (inc == 1 && mcnt < int'(W)) mcnt++;
         mq    = nq;
         mdone = (mcnt == int'(W)) ? 1 : 0;
      end
      #1;
      check("q",          32'(bus.q),          32'(mq));
      check("cnt",        32'(bus.cnt),        32'(mcnt));
      check("done",       32'(bus.done),       32'(mdone));
      check("done_pulse", 32'(bus.done_pulse), 32'(mpulse));
      check("sout_msb",   32'(bus.sout_msb),   32'(mq / 128));
      check("sout_lsb",   32'(bus.sout_lsb),   32'(mq % 2));
   endtask

   initial begin
      logic [7:0] shl_seq [8];
      logic [2:0] rm;
      n_tests = 0;
      n_fail  = 0;
      mq = 0; mcnt = 0; mdone = 0; mpulse = 0;
      rst = 1'b0; bus.en = 1'b0; bus.mode = 3'd0; bus.din = '0;
      bus.sin_r = 1'b0; bus.sin_l = 1'b0;
      shl_seq = '{8'h02, 8'h05, 8'h0B, 8'h17, 8'h2F, 8'h5F, 8'hBF, 8'h7F};

      // Reset wins over a simultaneous load.
      step(1, 1, 3'd5, 8'hFF, 0, 0);
      check("rst_q", 32'(bus.q), 32'h0000_00A5);
      check("rst_cnt", 32'(bus.cnt), 32'd0);

      // Load 0x81 and shift left eight times (first bit in is 0, then 1s).
      step(0, 1, 3'd5, 8'h81, 0, 0);
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 3'd1, 8'h00, (i == 0) ? 1'b0 : 1'b1, 0);
         check("shl_q", 32'(bus.q), 32'(shl_seq[i]));
         check("shl_cnt", 32'(bus.cnt), 32'(i + 1));
         check("shl_pulse", 32'(bus.done_pulse), (i == 7) ? 32'd1 : 32'd0);
      end
      check("shl_done", 32'(bus.done), 32'd1);

      // Saturation: further shifts move data but the counter stays put.
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 3'd2, 8'h00, 0, 0);
         check("sat_cnt", 32'(bus.cnt), 32'd8);
         check("sat_pulse", 32'(bus.done_pulse), 32'd0);
      end
      check("sat_q", 32'(bus.q), 32'h0000_000F);

      // Rotates and arithmetic shift right.
      step(0, 1, 3'd5, 8'h96, 0, 0);
      check("load_done_clr", 32'(bus.done), 32'd0);
      step(0, 1, 3'd4, 8'h00, 0, 0);
      check("ror", 32'(bus.q), 32'h0000_004B);
      step(0, 1, 3'd3, 8'h00, 0, 0);
      check("rol", 32'(bus.q), 32'h0000_0096);
      step(0, 1, 3'd7, 8'h00, 0, 0);
      check("asr_neg", 32'(bus.q), 32'h0000_00CB);
      step(0, 1, 3'd5, 8'h4B, 0, 0);
      step(0, 1, 3'd7, 8'h00, 0, 0);
      check("asr_pos", 32'(bus.q), 32'h0000_0025);

      // Enable low freezes everything; hold mode does not count.
      for (int i = 0; i < 4; i++) step(0, 0, 3'd1, 8'hFF, 1, 1);
      check("en0_q", 32'(bus.q), 32'h0000_0025);
      check("en0_cnt", 32'(bus.cnt), 32'd1);
      step(0, 1, 3'd0, 8'hFF, 1, 1);
      check("hold_cnt", 32'(bus.cnt), 32'd1);

      // Clear goes to zero, not the reset value; reset aborts a shift-out.
      step(0, 1, 3'd6, 8'hFF, 1, 1);
      check("clr_q", 32'(bus.q), 32'd0);
      step(0, 1, 3'd5, 8'h3C, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 3'd1, 8'h00, 0, 0);
      check("mid_q", 32'(bus.q), 32'h0000_00C0);
      step(1, 1, 3'd1, 8'h00, 1, 1);
      check("midrst_q", 32'(bus.q), 32'h0000_00A5);
      check("midrst_pulse", 32'(bus.done_pulse), 32'd0);

      // Random traffic, biased toward counting modes so done is reached often.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 9) == 0) rm = ($urandom_range(0, 1) == 0) ? 3'd5 : 3'd6;
         else begin
            case ($urandom_range(0, 5))
               0: rm = 3'd0;
               1: rm = 3'd1;
               2: rm = 3'd2;
               3: rm = 3'd3;
               4: rm = 3'd4;
               default: rm = 3'd7;
            endcase
         end
         step(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) != 0), rm,
              8'($urandom), 1'($urandom), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
